// File: rtl/exec_wb_stage.sv
// exec_wb_stage: multi-cycle ALU with a four-cycle shift-add multiplier and a write-back handshake
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   in_valid/in_ready  - request handshake (ready only while idle)
//   op, rd, crs, crt   - opcode, destination index, operands A and B
//   dw, rw, rg_we      - write-back data, index and enable (enable high one cycle)
//   flag_z, flag_c     - zero and carry/borrow of the last written result
//   busy               - high whenever an operation is in flight
module exec_wb_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [0:2] op,
    input  logic [0:1] rd,
    input  logic [0:3] crs,
    input  logic [0:3] crt,
    output logic [0:3] dw,
    output logic [0:1] rw,
    output logic       rg_we,
    output logic       flag_z,
    output logic       flag_c,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

    state_t     state_q, state_d;
    logic [0:1] cnt_q, cnt_d, rd_q, rd_d, rw_q, rw_d;
    logic [0:2] op_q, op_d;
    logic [0:3] a_q, a_d, b_q, b_d, dw_q, dw_d, alu_r;
    logic [0:7] acc_q, acc_d, mul_sum;
    logic [0:4] sum;
    logic       fz_q, fz_d, fc_q, fc_d, alu_c;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        dw_d    = dw_q;
        rw_d    = rw_q;
        fz_d    = fz_q;
        fc_d    = fc_q;
        sum     = {1'b0, a_q} + {1'b0, b_q};
        // b is shifted right each step, so its LSB selects the partial product a << step
        mul_sum = acc_q + (b_q[3] ? (8'(a_q) << cnt_q) : 8'd0);
        alu_r   = op_q == 3'b000 ? sum[1:4] :
                  op_q == 3'b001 ? a_q - b_q :
                  op_q == 3'b010 ? a_q & b_q :
                  op_q == 3'b011 ? a_q | b_q :
                  op_q == 3'b100 ? a_q ^ b_q :
                  op_q == 3'b101 ? {3'b000, a_q < b_q} :
                  op_q == 3'b110 ? {a_q[1:3], 1'b0} : 4'd0;
        alu_c   = op_q == 3'b000 ? sum[0] :
                  op_q == 3'b001 ? a_q < b_q :
                  op_q == 3'b110 ? a_q[0] : 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d    = op;
                rd_d    = rd;
                a_d     = crs;
                b_d     = crt;
                acc_d   = 8'd0;
                cnt_d   = 2'd0;
                state_d = op == 3'b111 ? MUL : EXEC;
            end
            EXEC: begin
                state_d = WB;
                dw_d    = alu_r;
                rw_d    = rd_q;
                fz_d    = alu_r == 4'd0;
                fc_d    = alu_c;
            end
            MUL: begin
                acc_d = mul_sum;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = WB;
                    dw_d    = mul_sum[4:7];
                    rw_d    = rd_q;
                    fz_d    = mul_sum[4:7] == 4'd0;
                    fc_d    = |mul_sum[0:3];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            dw_q    <= '0;
            rw_q    <= '0;
            fz_q    <= 1'b0;
            fc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            dw_q    <= dw_d;
            rw_q    <= rw_d;
            fz_q    <= fz_d;
            fc_q    <= fc_d;
        end
    end

    assign in_ready = state_q == IDLE;
    assign busy     = state_q != IDLE;
    assign rg_we    = state_q == WB;
    assign dw       = dw_q;
    assign rw       = rw_q;
    assign flag_z   = fz_q;
    assign flag_c   = fc_q;
endmodule

// File: tb/tb_exec_wb_stage.sv
// tb_exec_wb_stage: randomized and directed checks of exec_wb_stage against an arithmetic reference model
module tb_exec_wb_stage;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [0:2] op = '0;
    logic [0:1] rd = '0;
    logic [0:3] crs = '0;
    logic [0:3] crt = '0;
    logic [0:3] dw;
    logic [0:1] rw;
    logic       rg_we, flag_z, flag_c, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int rf [4];

    exec_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .crs(crs), .crt(crt), .dw(dw), .rw(rw),
        .rg_we(rg_we), .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic calc(input int o, input int a, input int b, output int r, output int c);
        int p;
        case (o)
            0: p = a + b;
            1: p = a - b + 16;
            2: p = a & b;
            3: p = a | b;
            4: p = a ^ b;
            5: p = (a < b) ? 1 : 0;
            6: p = a * 2;
            default: p = a * b;
        endcase
        r = p % 16;
        c = (o == 1) ? int'(a < b) : (o == 0 || o == 6 || o == 7) ? int'(p > 15) : 0;
    endtask

    // Starts and ends on a falling edge with the stage expected idle; operands are
    // scrambled while busy with in_valid held high to prove requests are ignored.
    task automatic run_op(input int o, input int d, input int a, input int b);
        int r, c, lat, writes;
        calc(o, a, b, r, c);
        lat = (o == 7) ? 5 : 2;
        writes = 0;
        chk("ready_idle", int'(in_ready), 1);
        in_valid = 1'b1;
        op = 3'(o); rd = 2'(d); crs = 4'(a); crt = 4'(b);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            op = 3'($urandom_range(0, 7)); rd = 2'($urandom_range(0, 3));
            crs = 4'($urandom_range(0, 15)); crt = 4'($urandom_range(0, 15));
            chk("busy", int'(busy), 1);
            chk("ready_busy", int'(in_ready), 0);
            chk("rg_we", int'(rg_we), int'(i == lat));
            if (rg_we) begin
                writes++;
                rf[rw] = int'(dw);
            end
            if (i == lat) begin
                chk("dw", int'(dw), r);
                chk("rw", int'(rw), d);
                chk("flag_z", int'(flag_z), int'(r == 0));
                chk("flag_c", int'(flag_c), c);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("writes", writes, 1);
        chk("ready_again", int'(in_ready), 1);
        chk("we_after", int'(rg_we), 0);
        chk("dw_hold", int'(dw), r);
        chk("z_hold", int'(flag_z), int'(r == 0));
        chk("c_hold", int'(flag_c), c);
    endtask

    task automatic chk_reset_vals();
        chk("rst_we", int'(rg_we), 0);
        chk("rst_dw", int'(dw), 0);
        chk("rst_rw", int'(rw), 0);
        chk("rst_z", int'(flag_z), 0);
        chk("rst_c", int'(flag_c), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(in_ready), 1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_post_rst", int'(in_ready), 1);
        @(negedge clk);
        run_op(0, 2, 9, 8);
        run_op(1, 0, 6, 6);
        run_op(1, 1, 2, 3);
        run_op(7, 3, 3, 5);
        run_op(7, 1, 4, 4);
        run_op(6, 2, 12, 1);
        run_op(5, 3, 3, 9);
        run_op(3, 0, 1, 0);
        run_op(3, 1, 2, 0);
        run_op(3, 2, 3, 0);
        run_op(3, 3, 15, 0);
        chk("rf0", rf[0], 1);
        chk("rf1", rf[1], 2);
        chk("rf2", rf[2], 3);
        chk("rf3", rf[3], 15);
        for (int n = 0; n < 40; n++)
            run_op($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
        chk("ready_pre_abort", int'(in_ready), 1);
        in_valid = 1'b1;
        op = 3'b111; rd = 2'd2; crs = 4'd7; crt = 4'd7;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1 chk_reset_vals();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_we", int'(rg_we), 0);
            chk("abort_busy", int'(busy), 0);
        end
        rst_n = 1'b1;
        #1 chk("ready_after_abort", int'(in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("idle_we", int'(rg_we), 0);
        end
        run_op(4, 1, 10, 5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
